// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle datapath: FSM states, instruction
// classes from the external decoder, and ALU operation codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_R = 3'd0,
    ALU_I = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    BEQ   = 3'd4,
    JR    = 3'd5,
    HALT  = 3'd6
  } cls_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  // Signed overflow of a two's-complement add, from operand and result sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: eight ops, zero flag, and signed overflow for ADD/SUB.
module mc_alu
  import mc_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         ovf
);

  localparam int SHW = $clog2(N);

  logic [N-1:0]   sum_s;
  logic [N-1:0]   diff_s;
  logic [SHW-1:0] shamt_s;
  logic           lt_s;

  assign sum_s   = a + b;
  assign diff_s  = a - b;
  assign shamt_s = b[SHW-1:0];
  assign lt_s    = $signed(a) < $signed(b);

  // Operation select; undefined codes give a zero result and no overflow.
  always_comb begin
    result = {N{1'b0}};
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum_s;
        ovf    = add_ovf(a[N-1], b[N-1], sum_s[N-1]);
      end
      ALU_SUB: begin
        result = diff_s;
        ovf    = add_ovf(a[N-1], ~b[N-1], diff_s[N-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(N-1){1'b0}}, lt_s};
      ALU_SLL: result = a << shamt_s;
      ALU_SRL: result = a >> shamt_s;
      default: begin
        result = {N{1'b0}};
        ovf    = 1'b0;
      end
    endcase
  end

  assign zero = (result == {N{1'b0}});

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one wait-stated
// memory port between instruction fetch and data access; decode is external.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int           N        = 16,
  parameter int           REGBITS  = 3,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   cls,
  input  logic [3:0]   alucontrol,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-1:0] pc,
  output logic [N-1:0] ir,
  output logic [2:0]   state,
  output logic         retire,
  output logic         halted,
  output logic         ovf
);

  localparam int           IMMW    = N - 4 - 2 * REGBITS;
  localparam int           NREG    = 2 ** REGBITS;
  localparam logic [N-1:0] PC_STEP = {{(N-1){1'b0}}, 1'b1};

  // rd sits below rt, so the word must also hold three full register fields.
  if ((IMMW < 2) || (N - 4 - 3 * REGBITS < 0)) begin : g_bad_layout
    $fatal(1, "mc_datapath: instruction fields do not fit in N bits");
  end

  state_e       state_r;
  logic [N-1:0] pc_r;
  logic [N-1:0] ir_r;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic [N-1:0] aluout_r;
  logic [N-1:0] mdr_r;
  logic [N-1:0] tgt_r;
  logic [N-1:0] rf_r [NREG];
  logic         retire_r;
  logic         halted_r;
  logic         ovf_r;

  cls_e               cls_s;
  logic [REGBITS-1:0] rs_s;
  logic [REGBITS-1:0] rt_s;
  logic [REGBITS-1:0] rd_s;
  logic [N-1:0]       imm_s;
  logic [N-1:0]       alu_b_s;
  logic [3:0]         alu_op_s;
  logic [N-1:0]       alu_y_s;
  logic               alu_zero_s;
  logic               alu_ovf_s;
  logic [REGBITS-1:0] wb_idx_s;
  logic [N-1:0]       wb_data_s;
  logic               rf_we_s;

  assign cls_s = cls_e'(cls);
  assign rs_s  = ir_r[N-5 -: REGBITS];
  assign rt_s  = ir_r[N-5-REGBITS -: REGBITS];
  assign rd_s  = ir_r[N-5-2*REGBITS -: REGBITS];
  assign imm_s = {{(N-IMMW){ir_r[IMMW-1]}}, ir_r[IMMW-1:0]};

  // Second ALU operand and op: immediates for I-type and memory, SUB compare for BEQ.
  always_comb begin
    alu_b_s  = b_r;
    alu_op_s = alucontrol;
    case (cls_s)
      ALU_R: begin
        alu_b_s  = b_r;
        alu_op_s = alucontrol;
      end
      ALU_I: begin
        alu_b_s  = imm_s;
        alu_op_s = alucontrol;
      end
      LOAD, STORE: begin
        alu_b_s  = imm_s;
        alu_op_s = ALU_ADD;
      end
      BEQ: begin
        alu_b_s  = b_r;
        alu_op_s = ALU_SUB;
      end
      default: begin
        alu_b_s  = b_r;
        alu_op_s = alucontrol;
      end
    endcase
  end

  mc_alu #(.N(N)) u_alu (
    .a      (a_r),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_y_s),
    .zero   (alu_zero_s),
    .ovf    (alu_ovf_s)
  );

  assign wb_idx_s  = (cls_s == ALU_R) ? rd_s : rt_s;
  assign wb_data_s = (cls_s == LOAD) ? mdr_r : aluout_r;
  assign rf_we_s   = (state_r == S_WB) && (wb_idx_s != {REGBITS{1'b0}});

  // The request follows the state directly so the fetch address is presented during reset.
  assign mem_req   = (state_r == S_FETCH) || (state_r == S_MEM);
  assign mem_we    = (state_r == S_MEM) && (cls_s == STORE);
  assign mem_addr  = (state_r == S_FETCH) ? pc_r : aluout_r;
  assign mem_wdata = b_r;

  assign pc     = pc_r;
  assign ir     = ir_r;
  assign state  = state_r;
  assign retire = retire_r;
  assign halted = halted_r;
  assign ovf    = ovf_r;

  // Register file; entry 0 is never written so it always reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {N{1'b0}};
      end
    end else if (rf_we_s) begin
      rf_r[wb_idx_s] <= wb_data_s;
    end
  end

  // Instruction sequencer with its architectural and pipeline latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_FETCH;
      pc_r     <= RESET_PC;
      ir_r     <= {N{1'b0}};
      a_r      <= {N{1'b0}};
      b_r      <= {N{1'b0}};
      aluout_r <= {N{1'b0}};
      mdr_r    <= {N{1'b0}};
      tgt_r    <= {N{1'b0}};
      retire_r <= 1'b0;
      halted_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      retire_r <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            ir_r    <= mem_rdata;
            pc_r    <= pc_r + PC_STEP;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r   <= rf_r[rs_s];
          b_r   <= rf_r[rt_s];
          tgt_r <= pc_r + imm_s;
          if (cls_s == HALT) begin
            halted_r <= 1'b1;
            state_r  <= S_HALT;
          end else begin
            state_r  <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_s)
            ALU_R, ALU_I: begin
              aluout_r <= alu_y_s;
              if (alu_ovf_s) begin
                ovf_r <= 1'b1;
              end
              state_r <= S_WB;
            end
            LOAD, STORE: begin
              aluout_r <= alu_y_s;
              state_r  <= S_MEM;
            end
            BEQ: begin
              if (alu_zero_s) begin
                pc_r <= tgt_r;
              end
              retire_r <= 1'b1;
              state_r  <= S_FETCH;
            end
            JR: begin
              pc_r     <= a_r;
              retire_r <= 1'b1;
              state_r  <= S_FETCH;
            end
            default: begin
              // An unknown class stops the machine rather than guessing.
              halted_r <= 1'b1;
              state_r  <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls_s == LOAD) begin
              mdr_r   <= mem_rdata;
              state_r <= S_WB;
            end else begin
              retire_r <= 1'b1;
              state_r  <= S_FETCH;
            end
          end
        end
        S_WB: begin
          retire_r <= 1'b1;
          state_r  <= S_FETCH;
        end
        S_HALT: begin
          halted_r <= 1'b1;
          state_r  <= S_HALT;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: bench-side decoder and word memory, hand-computed results.
module tb_mc_datapath;
  import mc_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  cls;
  logic [3:0]  alucontrol;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [2:0]  state;
  logic        retire;
  logic        halted;
  logic        ovf;

  logic [15:0] mem [256];
  int          checks;
  int          passes;
  int          retire_cnt;
  int          cyc;

  mc_datapath #(.N(16), .REGBITS(3), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .cls        (cls),
    .alucontrol (alucontrol),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ir         (ir),
    .state      (state),
    .retire     (retire),
    .halted     (halted),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  // Bench decoder: opcode nibble -> instruction class and ALU op.
  always_comb begin
    cls        = HALT;
    alucontrol = ALU_ADD;
    case (ir[15:12])
      4'd0:  begin cls = ALU_R; alucontrol = ALU_ADD; end
      4'd1:  begin cls = ALU_R; alucontrol = ALU_SUB; end
      4'd2:  begin cls = ALU_I; alucontrol = ALU_ADD; end
      4'd3:  cls = LOAD;
      4'd4:  cls = STORE;
      4'd5:  cls = BEQ;
      4'd6:  cls = JR;
      4'd7:  cls = HALT;
      4'd8:  begin cls = ALU_R; alucontrol = ALU_AND; end
      4'd9:  begin cls = ALU_R; alucontrol = ALU_OR;  end
      4'd10: begin cls = ALU_R; alucontrol = ALU_XOR; end
      4'd11: begin cls = ALU_R; alucontrol = ALU_SLT; end
      4'd12: begin cls = ALU_R; alucontrol = ALU_SLL; end
      4'd13: begin cls = ALU_R; alucontrol = ALU_SRL; end
      4'd14: begin cls = ALU_R; alucontrol = 4'd8;    end
      default: cls = HALT;
    endcase
  end

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 3'b000};
  endfunction

  function automatic logic [15:0] ii(input logic [3:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock; stores land in memory at the edge where the request completes.
  task automatic step();
    logic        wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    wr = mem_req && mem_we && mem_ready;
    wa = mem_addr[7:0];
    wd = mem_wdata;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
    if (retire) retire_cnt++;
  endtask

  // Run until retire, inserting wait states; checks the data address in every MEM cycle.
  task automatic run_instr(input int fs, input int ms, input logic [15:0] maddr, output int n);
    int f;
    int m;
    f = fs;
    m = ms;
    n = 0;
    do begin
      if (state == S_FETCH) begin
        mem_ready = (f == 0);
        if (f > 0) f--;
      end else if (state == S_MEM) begin
        chk16("mem_addr_stable", mem_addr, maddr);
        mem_ready = (m == 0);
        if (m > 0) m--;
      end else begin
        mem_ready = 1'b1;
      end
      step();
      n++;
    end while (!retire && n < 40);
    chk1("retire_seen", retire, 1'b1);
  endtask

  logic [2:0]  tab_dst [10] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd0, 3'd6, 3'd7, 3'd6};
  logic [15:0] tab_val [10] = '{16'h7FFE, 16'h0013, 16'h8001, 16'h0001, 16'h000C,
                                16'h1FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000};

  initial begin
    checks = 0;
    passes = 0;
    retire_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = ii(4'd2, 3'd0, 3'd1, 6'd5);
    mem[1]   = ii(4'd2, 3'd0, 3'd2, 6'd3);
    mem[2]   = ri(4'd1, 3'd1, 3'd2, 3'd3);
    mem[3]   = ii(4'd2, 3'd0, 3'd5, 6'd16);
    mem[4]   = ii(4'd5, 3'd1, 3'd1, 6'h3F);
    mem[5]   = ii(4'd3, 3'd5, 3'd4, 6'd16);
    mem[6]   = ii(4'd3, 3'd5, 3'd1, 6'd20);
    mem[7]   = ri(4'd0, 3'd1, 3'd1, 3'd3);
    mem[8]   = ri(4'd8, 3'd3, 3'd1, 3'd6);
    mem[9]   = ri(4'd9, 3'd5, 3'd2, 3'd7);
    mem[10]  = ri(4'd10, 3'd1, 3'd3, 3'd6);
    mem[11]  = ri(4'd11, 3'd3, 3'd2, 3'd7);
    mem[12]  = ri(4'd12, 3'd2, 3'd4, 3'd6);
    mem[13]  = ri(4'd13, 3'd3, 3'd2, 3'd7);
    mem[14]  = ri(4'd0, 3'd2, 3'd4, 3'd0);
    mem[15]  = ri(4'd1, 3'd2, 3'd4, 3'd6);
    mem[16]  = ri(4'd14, 3'd1, 3'd1, 3'd7);
    mem[17]  = ri(4'd11, 3'd2, 3'd3, 3'd6);
    mem[18]  = ii(4'd2, 3'd0, 3'd6, 6'h3F);
    mem[19]  = ii(4'd6, 3'd6, 3'd0, 6'd0);
    mem[32]  = 16'hDEAD;
    mem[36]  = 16'h7FFF;
    mem[255] = ii(4'd2, 3'd0, 3'd7, 6'd7);

    // Reset held: fetch request at RESET_PC, everything cleared.
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b1);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk16("rst_state", {13'd0, state}, 16'd0);
    chk16("rst_pc", pc, 16'h0000);
    chk16("rst_ir", ir, 16'h0000);
    chk1("rst_retire", retire, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    #2 reset = 1'b1;
    step();
    chk16("fetch0_ir", ir, ii(4'd2, 3'd0, 3'd1, 6'd5));
    chk16("fetch0_pc", pc, 16'h0001);
    chk16("fetch0_state", {13'd0, state}, 16'd1);

    // ALU_I, ALU_I, ALU_R SUB.
    run_instr(0, 0, 16'h0000, cyc);
    chkn("addi1_cycles", cyc + 1, 4);
    chk16("r1_eq_5", dut.rf_r[1], 16'h0005);
    run_instr(0, 0, 16'h0000, cyc);
    chkn("addi2_cycles", cyc, 4);
    chk16("r2_eq_3", dut.rf_r[2], 16'h0003);
    run_instr(0, 0, 16'h0000, cyc);
    chkn("sub_cycles", cyc, 4);
    chk16("r3_eq_2", dut.rf_r[3], 16'h0002);
    chkn("retire_count", retire_cnt, 3);
    run_instr(0, 0, 16'h0000, cyc);
    chk16("r5_eq_16", dut.rf_r[5], 16'h0010);

    // BEQ with equal operands and imm -1 at pc 4 loops back to 4.
    run_instr(0, 0, 16'h0000, cyc);
    chkn("beq_cycles", cyc, 3);
    chk16("beq_pc", pc, 16'h0004);
    mem[4] = ii(4'd4, 3'd5, 3'd3, 6'd16);

    // STORE then LOAD at 0x20, three wait states in each MEM.
    run_instr(0, 3, 16'h0020, cyc);
    chkn("store_cycles", cyc, 7);
    chk16("store_data", mem[32], 16'h0002);
    run_instr(0, 3, 16'h0020, cyc);
    chkn("load_cycles", cyc, 8);
    chk16("r4_eq_r3", dut.rf_r[4], 16'h0002);

    // Fetch wait states plus overflow on ADD.
    run_instr(2, 0, 16'h0024, cyc);
    chkn("load_fetch_wait_cycles", cyc, 7);
    chk16("r1_7fff", dut.rf_r[1], 16'h7FFF);
    chk1("ovf_before", ovf, 1'b0);
    run_instr(0, 0, 16'h0000, cyc);
    chk16("add_wrap", dut.rf_r[3], 16'hFFFE);
    chk1("ovf_set", ovf, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_instr(0, 0, 16'h0000, cyc);
      chkn("alu_cycles", cyc, 4);
      chk16("alu_result", dut.rf_r[tab_dst[i]], tab_val[i]);
      chk1("ovf_sticky", ovf, 1'b1);
    end

    // JR to 0xFFFF, then PC wraps to 0 on the fetch.
    run_instr(0, 0, 16'h0000, cyc);
    chk16("r6_ffff", dut.rf_r[6], 16'hFFFF);
    run_instr(0, 0, 16'h0000, cyc);
    chkn("jr_cycles", cyc, 3);
    chk16("jr_pc", pc, 16'hFFFF);
    mem_ready = 1'b1;
    step();
    chk16("wrap_pc", pc, 16'h0000);
    chk16("wrap_ir", ir, ii(4'd2, 3'd0, 3'd7, 6'd7));
    run_instr(0, 0, 16'h0000, cyc);
    chk16("r7_eq_7", dut.rf_r[7], 16'h0007);

    // Reset in the middle of a LOAD's MEM wait.
    mem[0] = ii(4'd3, 3'd0, 3'd1, 6'd8);
    mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    repeat (2) step();
    chk16("mid_mem_state", {13'd0, state}, 16'd3);
    chk16("mid_mem_addr", mem_addr, 16'h0008);
    #2 reset = 1'b0;
    #1;
    chk16("rst_mid_state", {13'd0, state}, 16'd0);
    chk16("rst_mid_pc", pc, 16'h0000);
    chk16("rst_mid_addr", mem_addr, 16'h0000);
    chk1("rst_mid_req", mem_req, 1'b1);
    chk1("rst_mid_ovf", ovf, 1'b0);
    for (int i = 1; i < 8; i++) chk16("rst_mid_reg", dut.rf_r[i], 16'h0000);
    step();
    chk16("rst_hold_state", {13'd0, state}, 16'd0);

    // HALT: stays halted with no memory requests.
    #2 reset = 1'b1;
    mem[0] = ii(4'd7, 3'd0, 3'd0, 6'd0);
    mem_ready = 1'b1;
    retire_cnt = 0;
    repeat (2) step();
    chk1("halted", halted, 1'b1);
    chk1("halt_req", mem_req, 1'b0);
    chk16("halt_state", {13'd0, state}, 16'd5);
    repeat (8) step();
    chk1("halted_hold", halted, 1'b1);
    chk1("halt_req_hold", mem_req, 1'b0);
    chk16("halt_pc", pc, 16'h0001);
    chkn("halt_no_retire", retire_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multicycle successor to the single-cycle 16-bit datapath. It sequences every instruction through an internal fetch/decode/execute/memory/writeback FSM. It holds architectural state (PC, register file) and non-architectural latches (IR, A, B, ALUOut, MDR), and shares one memory port, with wait states, between instruction fetch and data access. Instruction decode stays external: the decoder reads `ir` and returns an instruction class plus an ALU op.

## Interface
- `N`, 16: data, address and instruction width.
- `REGBITS`, 3: register index width, giving 2^REGBITS registers.
- `RESET_PC`, 0: PC value after reset.
- Derived: `IMMW = N-4-2*REGBITS`. Must be ≥2; elaboration-time assert.

Ports:
- `clk` — input, 1: rising-edge clock.
- `reset` — input, 1: asynchronous, active-low reset.
- `cls` — input, 3: class of the instruction in `ir`, decoded by the external decoder. Values: ALU_R, ALU_I, LOAD, STORE, BEQ, JR, HALT.
- `alucontrol` — input, 4: ALU op for the instruction in `ir`.
- `mem_req` — output, 1: memory request valid.
- `mem_we` — output, 1: write request when 1, read when 0.
- `mem_addr` — output, N: word address.
- `mem_wdata` — output, N: store data.
- `mem_rdata` — input, N: read data. Valid in the cycle `mem_ready` is high.
- `mem_ready` — input, 1: completes the current request.
- `pc` — output, N: program counter.
- `ir` — output, N: instruction register.
- `state` — output, 3: FSM state, for debug.
- `retire` — output, 1: one-cycle pulse when an instruction completes.
- `halted` — output, 1: high while in HALT.
- `ovf` — output, 1: sticky signed-overflow flag.

## Operation
- **Instruction fields:**
  - op = `ir[N-1:N-4]`, read by the decoder only.
  - rs = next REGBITS bits down, then rt, then rd.
  - imm = `ir[IMMW-1:0]`, sign-extended to N.
- **FETCH:** drive `mem_req=1`, `mem_we=0`, `mem_addr=pc`. Hold until `mem_ready`. On ready: `ir<=mem_rdata`, `pc<=pc+1` → DECODE.
- **DECODE:** `A<=rf[rs]`, `B<=rf[rt]`, `tgt<=pc+sext(imm)` (relative to the incremented PC).
  - cls HALT → HALT.
  - Otherwise → EXEC.
- **EXEC:**
  - ALU_R: `ALUOut<=A op B` → WB.
  - ALU_I: `ALUOut<=A op sext(imm)` → WB.
  - LOAD/STORE: `ALUOut<=A+sext(imm)` → MEM.
  - BEQ: if A==B then `pc<=tgt`; retire → FETCH.
  - JR: `pc<=A`; retire → FETCH.
- **MEM:** drive `mem_req=1`, `mem_addr=ALUOut`, `mem_we=(cls==STORE)`, `mem_wdata=B`. Hold until `mem_ready`.
  - LOAD: `MDR<=mem_rdata` → WB.
  - STORE: retire → FETCH.
- **WB:** writes LOAD ? MDR : ALUOut.
  - Destination is rd for ALU_R, rt for ALU_I/LOAD.
  - Retire → FETCH.
- **HALT:** `mem_req=0`, `halted=1`. Leaves only on reset.
- **ALU ops:** ADD, SUB, AND, OR, XOR, SLT (signed), SLL, SRL.
  - Shift amount = `B[$clog2(N)-1:0]`.
  - Undefined codes yield 0.
- **Overflow:** signed overflow on ADD/SUB sets `ovf` in EXEC. `ovf` clears only on reset, and the wrapped result is still written.
- **Register 0:** reads 0; writes to it are discarded.
- **PC wrap:** PC arithmetic is modulo 2^N, so 2^N-1 wraps to 0.
- **Memory handshake:**
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high and `mem_ready` is low.
  - `mem_ready` is ignored when `mem_req` is low.
  - A ready in the request's first cycle gives zero wait states.

## Timing
- **Reset (asynchronous, active-low):**
  - State → FETCH.
  - `pc=RESET_PC`; `ir`, A, B, ALUOut, MDR and all registers = 0.
  - `retire=0`, `halted=0`, `ovf=0`.
  - `mem_req` is combinational from state, so it is 1 with `mem_addr=RESET_PC` as soon as reset is held, and stays so after release.
- **Reset mid-operation:** any in-flight request is abandoned without completing. Memory must tolerate a dropped or re-targeted request.
- **Cycles with zero wait states:**
  - BEQ/JR: 3 cycles.
  - STORE, ALU_R, ALU_I: 4 cycles.
  - LOAD: 5 cycles.
  - Each `mem_ready`-low cycle in FETCH or MEM adds 1 cycle.
- **`retire`:** asserted in the final cycle of the instruction's last state, together with the architectural update at that edge.

## Structure
- Package `mc_pkg` holds:
  - the state enum: FETCH, DECODE, EXEC, MEM, WB, HALT;
  - the cls enum;
  - the 4-bit ALU op constants.
- Sub-module `mc_alu`: combinational, parametrised on N. Produces result, zero and overflow.
- The register file is an internal array with the register-0 rule applied.

## Test plan
- **Reset/fetch:** hold `reset=0` → `mem_req=1`, `mem_addr=0`. Release with `mem_ready=1` → after 1 edge `ir` = mem word 0 and `pc=1`.
- **ALU_I then ALU_R:** r1 = 0+5 and r2 = 0+3 via ALU_I, then r3 = r1 SUB r2 → r3 = 2. `retire` pulses 3 times, each instruction taking 4 cycles.
- **Overflow:** r1 = 0x7FFF, ADD r1+r1 → r3 = 0xFFFE and `ovf=1`. `ovf` stays 1 through 10 further instructions.
- **Load/store with wait states:** STORE r3→[0x20], then LOAD [0x20]→r4, with `mem_ready` low for 3 cycles in each MEM → r4 = r3. The LOAD takes 8 cycles and the address stays stable throughout.
- **BEQ, JR, wrap:** BEQ with equal operands and imm = -1 at pc 4 → next fetch at 4. JR with A=0xFFFF, then a fetch → `pc` = 0x0000.
- **HALT/reset:** a HALT instruction → `halted=1` and `mem_req=0` indefinitely. Assert `reset` in the middle of a MEM wait → next cycle is FETCH at RESET_PC and registers are 0.
